// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART receiver and transmitter:
//                oversampling ratio, tick-counter width, majority-vote sample
//                indices, parity-type constants and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Samples per bit. Only 8 is supported in this release.
    localparam int unsigned c_oversample = 8;
    localparam int unsigned c_tick_w     = $clog2(c_oversample);

    // The three mid-bit samples voted on. The decision is made on the last one.
    localparam logic [c_tick_w-1:0] c_maj_idx_a = c_tick_w'(3);
    localparam logic [c_tick_w-1:0] c_maj_idx_b = c_tick_w'(4);
    localparam logic [c_tick_w-1:0] c_maj_idx_c = c_tick_w'(5);

    // Values of i_par_type.
    localparam logic c_par_even = 1'b0;
    localparam logic c_par_odd  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rx_bit_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_bit_sampler
//  Description : Per-bit tick counter and 3-sample majority voter.
//  Ports       : i_clk, i_rst      clock / synchronous active-high reset
//                i_sample_en       oversampling tick
//                i_clear           hold the tick counter at 0 (receiver idle)
//                i_rx_s            synchronised serial line
//                o_bit_value       majority of the samples at counts 3, 4, 5
//                o_mid_tick        tick on which o_bit_value is decided
//                o_bit_done        last tick of the bit
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = c_oversample
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample_en,
    input  logic i_clear,
    input  logic i_rx_s,
    output logic o_bit_value,
    output logic o_mid_tick,
    output logic o_bit_done
);

    localparam logic [c_tick_w-1:0] c_last_tick = c_tick_w'(OVERSAMPLE - 1);

    logic [c_tick_w-1:0] r_cnt;
    logic                r_samp_a;
    logic                r_samp_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_samp_a <= 1'b0;
            r_samp_b <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_sample_en) begin
            r_cnt <= (r_cnt == c_last_tick) ? '0 : r_cnt + 1'b1;
            if (r_cnt == c_maj_idx_a) r_samp_a <= i_rx_s;
            if (r_cnt == c_maj_idx_b) r_samp_b <= i_rx_s;
        end
    end

    // Third vote is the live sample, so the decision is ready on the count-5 tick.
    assign o_bit_value = (r_samp_a & r_samp_b) | (r_samp_a & i_rx_s) | (r_samp_b & i_rx_s);
    assign o_mid_tick  = i_sample_en & ~i_clear & (r_cnt == c_maj_idx_c);
    assign o_bit_done  = i_sample_en & ~i_clear & (r_cnt == c_last_tick);

endmodule : rx_bit_sampler
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver with optional even/odd parity.
//  Ports       : i_clk, i_rst      clock / synchronous active-high reset
//                i_rx              asynchronous serial line (idle high)
//                i_sample_en       tick at OVERSAMPLE x baud
//                i_par_en          frame carries a parity bit
//                i_par_type        0 = even, 1 = odd
//                o_data            last received data word
//                o_data_valid      one-cycle pulse per completed frame
//                o_par_err         parity mismatch on the last frame
//                o_stop_err        stop bit sampled low on the last frame
//                o_busy            receiver not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = c_oversample
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    input  logic                  i_sample_en,
    input  logic                  i_par_en,
    input  logic                  i_par_type,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_stop_err,
    output logic                  o_busy
);

    localparam int unsigned c_idx_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_WIDTH - 1);

    rx_state_t             r_state,      w_state_nxt;
    logic                  r_rx_meta,    r_rx_s;
    logic [c_idx_w-1:0]    r_idx,        w_idx_nxt;
    logic [DATA_WIDTH-1:0] r_shift,      w_shift_nxt;
    logic                  r_par_en_l,   w_par_en_l_nxt;
    logic                  r_par_type_l, w_par_type_l_nxt;
    logic                  r_par_acc,    w_par_acc_nxt;
    logic                  r_armed,      w_armed_nxt;
    logic [DATA_WIDTH-1:0] r_data,       w_data_nxt;
    logic                  r_par_err,    w_par_err_nxt;
    logic                  r_stop_err,   w_stop_err_nxt;
    logic                  r_valid,      w_valid_nxt;

    logic w_bit_value;
    logic w_mid_tick;
    logic w_bit_done;
    logic w_exp_par;

    rx_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sample_en (i_sample_en),
        .i_clear     (r_state == ST_IDLE),
        .i_rx_s      (r_rx_s),
        .o_bit_value (w_bit_value),
        .o_mid_tick  (w_mid_tick),
        .o_bit_done  (w_bit_done)
    );

    assign w_exp_par = (^r_shift) ^ (r_par_type_l == c_par_odd);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_shift      <= '0;
            r_par_en_l   <= 1'b0;
            r_par_type_l <= 1'b0;
            r_par_acc    <= 1'b0;
            r_armed      <= 1'b1;
            r_data       <= '0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_s       <= r_rx_meta;
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_par_en_l   <= w_par_en_l_nxt;
            r_par_type_l <= w_par_type_l_nxt;
            r_par_acc    <= w_par_acc_nxt;
            r_armed      <= w_armed_nxt;
            r_data       <= w_data_nxt;
            r_par_err    <= w_par_err_nxt;
            r_stop_err   <= w_stop_err_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_shift_nxt      = r_shift;
        w_par_en_l_nxt   = r_par_en_l;
        w_par_type_l_nxt = r_par_type_l;
        w_par_acc_nxt    = r_par_acc;
        w_armed_nxt      = r_armed;
        w_data_nxt       = r_data;
        w_par_err_nxt    = r_par_err;
        w_stop_err_nxt   = r_stop_err;
        w_valid_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // After a frame ending with the line low (break), a start bit
                // is only accepted once the line has been seen high again.
                if (i_sample_en) begin
                    if (r_rx_s) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt      = ST_START;
                        w_idx_nxt        = '0;
                        w_par_acc_nxt    = 1'b0;
                        w_par_en_l_nxt   = i_par_en;
                        w_par_type_l_nxt = i_par_type;
                    end
                end
            end
            ST_START: begin
                if (w_mid_tick && w_bit_value) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_bit_done) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_mid_tick) begin
                    w_shift_nxt = {w_bit_value, r_shift[DATA_WIDTH-1:1]};
                end
                if (w_bit_done) begin
                    if (r_idx == c_last_idx) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = r_par_en_l ? ST_PARITY : ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_mid_tick) begin
                    w_par_acc_nxt = w_bit_value ^ w_exp_par;
                end
                if (w_bit_done) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave on the mid tick so the next start edge is caught promptly.
                if (w_mid_tick) begin
                    w_data_nxt     = r_shift;
                    w_par_err_nxt  = r_par_en_l & r_par_acc;
                    w_stop_err_nxt = ~w_bit_value;
                    w_valid_nxt    = 1'b1;
                    w_armed_nxt    = w_bit_value;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_par_err    = r_par_err;
    assign o_stop_err   = r_stop_err;
    assign o_busy       = (r_state != ST_IDLE);

endmodule : uart_rx
`default_nettype wire
